// File: rtl/fxp_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fxp_mul_scheduler
// Purpose  : Round-robin scheduler that shares one pipelined fixed-point
//            multiplier (external PU) among N_REQ requesters. One operation
//            is issued per cycle. Requester IDs travel alongside the PU
//            latency so each product is routed back to its owner as a
//            one-hot strobe.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous, active-low reset
//            req_valid  - per-requester request valid        [N_REQ]
//            req_ready  - per-requester grant (one-hot/zero) [N_REQ]
//            req_a/b    - packed operands, slice i = requester i
//            pu_a/pu_b  - registered operands to the PU
//            pu_valid   - registered issue strobe to the PU
//            pu_result  - PU product, MUL_LAT cycles after pu_valid
//            rsp_valid  - one-hot response strobe (no backpressure)
//            rsp_data   - product for the strobed requester
//            busy       - an operation is issued or in flight
// Options  : FXP_SCHED_PRIO_EN - requester 0 gets strict priority; the rest
//            share round-robin over 1..N_REQ-1.
// Revision : 1.0 - initial release
// ============================================================================
module fxp_mul_scheduler #(
  parameter int N_REQ   = 4,
  parameter int n_int   = 4,
  parameter int n_mant  = 12,
  parameter int MUL_LAT = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_REQ-1:0]                      req_valid,
  output logic [N_REQ-1:0]                      req_ready,
  input  logic [N_REQ*(1+n_int+n_mant)-1:0]     req_a,
  input  logic [N_REQ*(1+n_int+n_mant)-1:0]     req_b,
  output logic [n_int+n_mant:0]                 pu_a,
  output logic [n_int+n_mant:0]                 pu_b,
  output logic                                  pu_valid,
  input  logic [n_int+n_mant:0]                 pu_result,
  output logic [N_REQ-1:0]                      rsp_valid,
  output logic [n_int+n_mant:0]                 rsp_data,
  output logic                                  busy
);

  localparam int W    = 1 + n_int + n_mant;
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] c_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [ID_W-1:0]    r_ptr;
  logic               w_any;
  logic [ID_W-1:0]    w_gnt;
  logic               w_xfer;

  logic               r_puValid;
  logic [W-1:0]       r_puA;
  logic [W-1:0]       r_puB;
  logic [ID_W-1:0]    r_issueId;

  logic [MUL_LAT-1:0] r_tagValid;
  logic [ID_W-1:0]    r_tagId [MUL_LAT];

  // --------------------------------------------------------------------------
  // Arbitration: scan from r_ptr upward with wrap, first requester wins.
  // --------------------------------------------------------------------------
  always_comb begin
    int idx;
    int base;
    idx   = 0;
    base  = 0;
    w_any = 1'b0;
    w_gnt = '0;
`ifdef FXP_SCHED_PRIO_EN
    if (req_valid[0]) begin
      w_any = 1'b1;
    end else begin
      // Pointer only ever names 1..N_REQ-1 here; the reset value 0 behaves as 1.
      base = (r_ptr == '0) ? 1 : int'(r_ptr);
      for (int k = 0; k < N_REQ - 1; k++) begin
        idx = base + k;
        if (idx >= N_REQ) idx = idx - (N_REQ - 1);
        if (!w_any && req_valid[idx]) begin
          w_any = 1'b1;
          w_gnt = ID_W'(idx);
        end
      end
    end
`else
    base = int'(r_ptr);
    for (int k = 0; k < N_REQ; k++) begin
      idx = base + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_any && req_valid[idx]) begin
        w_any = 1'b1;
        w_gnt = ID_W'(idx);
      end
    end
`endif
  end

  // Grants are suppressed while reset is asserted so nothing transfers.
  assign w_xfer    = rst && w_any;
  assign req_ready = w_xfer ? (c_ONE << w_gnt) : '0;

  // --------------------------------------------------------------------------
  // Pointer and issue stage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= '0;
      r_puValid <= 1'b0;
      r_puA     <= '0;
      r_puB     <= '0;
      r_issueId <= '0;
    end else begin
      r_puValid <= w_xfer;
      if (w_xfer) begin
        r_puA     <= req_a[int'(w_gnt)*W +: W];
        r_puB     <= req_b[int'(w_gnt)*W +: W];
        r_issueId <= w_gnt;
`ifdef FXP_SCHED_PRIO_EN
        // A priority grant to requester 0 leaves the rotation untouched.
        if (w_gnt != '0) begin
          r_ptr <= (int'(w_gnt) == N_REQ - 1) ? ID_W'(1) : w_gnt + ID_W'(1);
        end
`else
        r_ptr <= (int'(w_gnt) == N_REQ - 1) ? '0 : w_gnt + ID_W'(1);
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Tag pipeline: {valid, id} follows each op so the last stage lines up with
  // pu_result. Never stalls.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tagValid <= '0;
      for (int s = 0; s < MUL_LAT; s++) begin
        r_tagId[s] <= '0;
      end
    end else begin
      r_tagValid[0] <= r_puValid;
      r_tagId[0]    <= r_issueId;
      for (int s = 1; s < MUL_LAT; s++) begin
        r_tagValid[s] <= r_tagValid[s-1];
        r_tagId[s]    <= r_tagId[s-1];
      end
    end
  end

  assign pu_valid  = r_puValid;
  assign pu_a      = r_puA;
  assign pu_b      = r_puB;
  assign rsp_valid = r_tagValid[MUL_LAT-1] ? (c_ONE << r_tagId[MUL_LAT-1]) : '0;
  assign rsp_data  = pu_result;
  assign busy      = r_puValid | (|r_tagValid);

endmodule
`default_nettype wire

// File: tb/tb_fxp_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fxp_mul_scheduler
// Purpose  : Self-checking bench for fxp_mul_scheduler with a behavioural
//            PU model and a transaction-level scheduler reference.
// Options  : FXP_SCHED_PRIO_EN selects the priority-arbitration scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fxp_mul_scheduler;

  localparam int N   = 4;
  localparam int NI  = 4;
  localparam int NM  = 12;
  localparam int LAT = 2;
  localparam int W   = 1 + NI + NM;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   reqValid = '0;
  logic [N-1:0]   reqReady;
  logic [N*W-1:0] reqA = '0;
  logic [N*W-1:0] reqB = '0;
  logic [W-1:0]   puA;
  logic [W-1:0]   puB;
  logic           puValid;
  logic [W-1:0]   puResult;
  logic [N-1:0]   rspValid;
  logic [W-1:0]   rspData;
  logic           busy;

  always #5 clk = ~clk;

  fxp_mul_scheduler #(
    .N_REQ  (N),
    .n_int  (NI),
    .n_mant (NM),
    .MUL_LAT(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(reqValid),
    .req_ready(reqReady),
    .req_a    (reqA),
    .req_b    (reqB),
    .pu_a     (puA),
    .pu_b     (puB),
    .pu_valid (puValid),
    .pu_result(puResult),
    .rsp_valid(rspValid),
    .rsp_data (rspData),
    .busy     (busy)
  );

  // Signed fixed-point product, truncated to the operand format.
  function automatic logic [W-1:0] mulRef(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p[NM +: W];
  endfunction

  // Behavioural external PU: fixed LAT-cycle pipeline.
  logic [W-1:0] puPipe [LAT];
  always @(posedge clk) begin
    puPipe[0] <= mulRef(puA, puB);
    for (int s = 1; s < LAT; s++) puPipe[s] <= puPipe[s-1];
  end
  assign puResult = puPipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           mPtr = 0;
  int           nTests = 0;
  int           nFail = 0;
  int           expGnt;
  logic [N-1:0] expReady;
  logic [N-1:0] expRsp;
  logic [W-1:0] expData;
  logic         expBusy;

  // Requester picked by the arbitration rules, -1 when none is asking.
  function automatic int modelGrant(input logic [N-1:0] v, input int ptr);
`ifdef FXP_SCHED_PRIO_EN
    int start;
    if (v[0]) return 0;
    start = (ptr < 1) ? 1 : ptr;
    for (int k = 0; k < N - 1; k++) begin
      int i;
      i = 1 + ((start - 1 + k) % (N - 1));
      if (v[i]) return i;
    end
`else
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  // Called at the negedge: expectations for the current cycle.
  task automatic evaluate();
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    expGnt   = modelGrant(reqValid, mPtr);
    expReady = (expGnt >= 0) ? (N'(1) << expGnt) : '0;
    expRsp   = '0;
    expData  = 'x;
    foreach (q[i]) begin
      if (q[i].due == cyc) begin
        expRsp  = N'(1) << q[i].id;
        expData = q[i].data;
      end
    end
    expBusy = (q.size() > 0);
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    reqValid = v;
    reqA     = a;
    reqB     = b;
    @(negedge clk);
    evaluate();
  endtask

  // Commit the modelled transfer and move to just after the next edge.
  task automatic finishStep();
    exp_t e;
    if (expGnt >= 0) begin
      e.id   = expGnt;
      e.data = mulRef(reqA[expGnt*W +: W], reqB[expGnt*W +: W]);
      e.due  = cyc + 1 + LAT;
      q.push_back(e);
`ifdef FXP_SCHED_PRIO_EN
      if (expGnt != 0) mPtr = (expGnt == N - 1) ? 1 : expGnt + 1;
`else
      mPtr = (expGnt + 1) % N;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reqValid = '0;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    mPtr = 0;
  endtask

  function automatic logic [N*W-1:0] randOps();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom());
    return r;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [N+2:0] obs;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk);
      #1;
      reqValid = N'($urandom());
      @(negedge clk);
      obs = {reqReady, puValid, rspValid[0], busy};
      nTests++;
      if ({reqReady, puValid, rspValid, busy} !== '0) begin
        nFail++;
        $display("FAIL reset_outputs: got ready=%b puValid=%b rsp=%b busy=%b required all zero",
                 reqReady, puValid, rspValid, busy);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    mPtr = 0;
    step(4'b1111, randOps(), randOps());
    nTests++;
    if (reqReady !== 4'b0001) begin
      nFail++;
      $display("FAIL first_grant: got %b required 0001", reqReady);
    end
    finishStep();
    for (int t = 0; t < LAT + 2; t++) begin
      step('0, reqA, reqB);
      nTests++;
      if (rspValid !== expRsp || (expRsp != '0 && rspData !== expData)) begin
        nFail++;
        $display("FAIL reset_drain_rsp: got %b/%h required %b/%h", rspValid, rspData, expRsp, expData);
      end
      finishStep();
    end
  endtask

  task automatic test_single();
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    a = randOps();
    b = randOps();
    a[2*W +: W] = 17'h01800;   // 1.5
    b[2*W +: W] = 17'h02000;   // 2.0
    step(4'b0100, a, b);
    nTests++;
    if (reqReady !== 4'b0100) begin
      nFail++;
      $display("FAIL single_grant: got %b required 0100", reqReady);
    end
    finishStep();
    for (int t = 1; t <= LAT + 2; t++) begin
      step('0, a, b);
      if (t == 1) begin
        nTests++;
        if (puValid !== 1'b1 || puA !== 17'h01800 || puB !== 17'h02000) begin
          nFail++;
          $display("FAIL single_issue: got v=%b a=%h b=%h required 1/01800/02000", puValid, puA, puB);
        end
      end
      nTests++;
      if (rspValid !== ((t == LAT + 1) ? 4'b0100 : 4'b0000)) begin
        nFail++;
        $display("FAIL single_rsp_valid t=%0d: got %b", t, rspValid);
      end
      if (t == LAT + 1) begin
        nTests++;
        if (rspData !== 17'h03000) begin
          nFail++;
          $display("FAIL single_rsp_data: got %h required 03000", rspData);
        end
      end
      nTests++;
      if (busy !== (t <= LAT + 1)) begin
        nFail++;
        $display("FAIL single_busy t=%0d: got %b required %b", t, busy, (t <= LAT + 1));
      end
      finishStep();
    end
  endtask

  // Pointer sits at 3 after test_single granted requester 2.
  task automatic test_wrap();
    step(4'b1010, randOps(), randOps());
    nTests++;
    if (reqReady !== 4'b1000) begin
      nFail++;
      $display("FAIL wrap_grant3: got %b required 1000", reqReady);
    end
    finishStep();
    step(4'b1010, randOps(), randOps());
    nTests++;
    if (reqReady !== 4'b0010) begin
      nFail++;
      $display("FAIL wrap_grant1: got %b required 0010", reqReady);
    end
    finishStep();
    for (int t = 0; t < LAT + 2; t++) begin
      step('0, reqA, reqB);
      nTests++;
      if (rspValid !== expRsp || (expRsp != '0 && rspData !== expData)) begin
        nFail++;
        $display("FAIL wrap_rsp: got %b/%h required %b/%h", rspValid, rspData, expRsp, expData);
      end
      finishStep();
    end
  endtask

`ifndef FXP_SCHED_PRIO_EN
  task automatic test_round_robin();
    applyReset();
    for (int k = 0; k < 8 + LAT + 2; k++) begin
      step((k < 8) ? 4'b1111 : 4'b0000, randOps(), randOps());
      if (k < 8) begin
        nTests++;
        if (reqReady !== (4'b0001 << (k % 4))) begin
          nFail++;
          $display("FAIL rr_grant k=%0d: got %b required %b", k, reqReady, 4'b0001 << (k % 4));
        end
      end
      nTests++;
      if (rspValid !== expRsp || (expRsp != '0 && rspData !== expData)) begin
        nFail++;
        $display("FAIL rr_rsp k=%0d: got %b/%h required %b/%h", k, rspValid, rspData, expRsp, expData);
      end
      if (k > 0) begin
        nTests++;
        if (busy !== (k <= 8 + LAT)) begin
          nFail++;
          $display("FAIL rr_busy k=%0d: got %b required %b", k, busy, (k <= 8 + LAT));
        end
      end
      finishStep();
    end
  endtask
`endif

`ifdef FXP_SCHED_PRIO_EN
  task automatic test_prio();
    logic [N-1:0] want [8];
    want = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
    applyReset();
    for (int k = 0; k < 8 + LAT + 2; k++) begin
      step((k < 4) ? 4'b1111 : (k < 8) ? 4'b1110 : 4'b0000, randOps(), randOps());
      if (k < 8) begin
        nTests++;
        if (reqReady !== want[k]) begin
          nFail++;
          $display("FAIL prio_grant k=%0d: got %b required %b", k, reqReady, want[k]);
        end
      end
      nTests++;
      if (rspValid !== expRsp || (expRsp != '0 && rspData !== expData)) begin
        nFail++;
        $display("FAIL prio_rsp k=%0d: got %b/%h required %b/%h", k, rspValid, rspData, expRsp, expData);
      end
      finishStep();
    end
  endtask
`endif

  task automatic test_reset_inflight();
    step(4'b1111, randOps(), randOps());
    finishStep();
    step(4'b1111, randOps(), randOps());
    finishStep();
    reqValid = '0;
    rst = 1'b0;
    #1;
    nTests++;
    if (busy !== 1'b0 || rspValid !== '0 || puValid !== 1'b0) begin
      nFail++;
      $display("FAIL inflight_reset: got busy=%b rsp=%b puValid=%b required 0/0/0", busy, rspValid, puValid);
    end
    q.delete();
    mPtr = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int t = 0; t < LAT + 2; t++) begin
      step('0, reqA, reqB);
      nTests++;
      if (rspValid !== '0 || busy !== 1'b0) begin
        nFail++;
        $display("FAIL inflight_discard t=%0d: got rsp=%b busy=%b required 0/0", t, rspValid, busy);
      end
      finishStep();
    end
    step(4'b1111, randOps(), randOps());
    nTests++;
    if (reqReady !== 4'b0001) begin
      nFail++;
      $display("FAIL inflight_ptr0: got %b required 0001", reqReady);
    end
    finishStep();
    for (int t = 0; t < LAT + 2; t++) begin
      step('0, reqA, reqB);
      nTests++;
      if (rspValid !== expRsp || (expRsp != '0 && rspData !== expData)) begin
        nFail++;
        $display("FAIL inflight_rsp: got %b/%h required %b/%h", rspValid, rspData, expRsp, expData);
      end
      finishStep();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 80 + LAT + 2; k++) begin
      step((k < 80) ? N'($urandom()) : '0, randOps(), randOps());
      nTests++;
      if (reqReady !== expReady) begin
        nFail++;
        $display("FAIL rand_grant k=%0d: got %b required %b", k, reqReady, expReady);
      end
      nTests++;
      if (rspValid !== expRsp || (expRsp != '0 && rspData !== expData)) begin
        nFail++;
        $display("FAIL rand_rsp k=%0d: got %b/%h required %b/%h", k, rspValid, rspData, expRsp, expData);
      end
      nTests++;
      if (busy !== expBusy) begin
        nFail++;
        $display("FAIL rand_busy k=%0d: got %b required %b", k, busy, expBusy);
      end
      finishStep();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
`ifndef FXP_SCHED_PRIO_EN
    test_round_robin();
`else
    test_prio();
`endif
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
